// File: rtl/reg_access_ctrl_if.sv
// reg_access_ctrl_if: host command/response link bundling the valid/ready command and response channels.
interface reg_access_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_opcode;
    logic [31:0] cmd_id;
    logic [31:0] cmd_mask;
    logic [31:0] cmd_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_err;
    modport master (
        output cmd_valid, cmd_opcode, cmd_id, cmd_mask, cmd_in, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_out, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_id, cmd_mask, cmd_in, rsp_ready,
        output cmd_ready, rsp_valid, rsp_out, rsp_err
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: register file and sync-RAM access controller driven by a one-outstanding command link.
// Define RAC_HW_UPDATE_EN to add per-register hardware load ports (hw_we, hw_wdata).
module reg_access_ctrl #(
    parameter int NUM_REGS  = 4,
    parameter int REG_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    localparam int MEM_AW   = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    reg_access_ctrl_if.slave              bus,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_q,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [MEM_AW-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic [31:0]                   mem_rdata
`ifdef RAC_HW_UPDATE_EN
    ,
    input  logic [NUM_REGS-1:0]           hw_we,
    input  logic [NUM_REGS*REG_WIDTH-1:0] hw_wdata
`endif
);
    localparam int WORDS = (REG_WIDTH + 31) / 32;
    localparam int PW    = WORDS * 32;
    localparam int IW    = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int WW    = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [PW-1:0] WORD_ONES = PW'(32'hffff_ffff);
    localparam logic [PW-1:0] REG_ONES  = PW'({REG_WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_DATA, RSP} state_t;
    state_t state, state_n;

    logic [REG_WIDTH-1:0] r   [NUM_REGS];
    logic [REG_WIDTH-1:0] r_n [NUM_REGS];
    logic          accept, bad, reg_op, mem_op, reg_wr;
    logic [IW-1:0] idx;
    logic [WW-1:0] word;
    logic [PW-1:0] wm, wd;
    logic [31:0]   rd;

    assign idx    = bus.cmd_id[IW-1:0];
    assign word   = bus.cmd_mask[WW-1:0];
    assign reg_op = bus.cmd_opcode == 32'd1 || bus.cmd_opcode == 32'd2;
    assign mem_op = bus.cmd_opcode == 32'd3 || bus.cmd_opcode == 32'd4;
    assign bad    = bus.cmd_opcode > 32'd4
                 || (reg_op && (bus.cmd_id >= 32'(NUM_REGS) || bus.cmd_mask >= 32'(WORDS)))
                 || (mem_op && bus.cmd_id >= 32'(MEM_DEPTH));
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign reg_wr = accept && !bad && bus.cmd_opcode == 32'd1;
    // Write mask is clipped to REG_WIDTH so the top word truncates and padding never holds data.
    assign wm     = (WORD_ONES << {word, 5'b0}) & REG_ONES;
    assign wd     = PW'(bus.cmd_in) << {word, 5'b0};
    assign rd     = 32'(PW'(r[idx]) >> {word, 5'b0});

    assign bus.cmd_ready = state == IDLE && !reset;
    assign bus.rsp_valid = state == RSP;

    // Hardware load applies first; the command word then overrides only its addressed word.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef RAC_HW_UPDATE_EN
            r_n[i] = hw_we[i] ? hw_wdata[i*REG_WIDTH +: REG_WIDTH] : r[i];
`else
            r_n[i] = r[i];
`endif
            r_n[i] = (reg_wr && idx == IW'(i)) ? REG_WIDTH'((PW'(r_n[i]) & ~wm) | (wd & wm)) : r_n[i];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = accept ? ((bad || !mem_op) ? RSP : MEM_REQ) : IDLE;
            MEM_REQ:  state_n = mem_we ? RSP : MEM_DATA;
            MEM_DATA: state_n = RSP;
            RSP:      state_n = bus.rsp_ready ? IDLE : RSP;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            bus.rsp_out <= '0;
            bus.rsp_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
        end else begin
            state  <= state_n;
            mem_en <= state_n == MEM_REQ;
            mem_we <= state_n == MEM_REQ && bus.cmd_opcode == 32'd3;
            for (int i = 0; i < NUM_REGS; i++) r[i] <= r_n[i];
            if (accept && mem_op && !bad) begin
                mem_addr  <= bus.cmd_id[MEM_AW-1:0];
                mem_wdata <= bus.cmd_in;
            end
            if (accept) begin
                bus.rsp_err <= bad;
                bus.rsp_out <= bad ? 32'hBADC_0DE0 :
                               bus.cmd_opcode == 32'd0 ? 32'hDEAD_BEEF :
                               bus.cmd_opcode == 32'd2 ? rd : bus.cmd_in;
            end else if (state == MEM_DATA) begin
                bus.rsp_out <= mem_rdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign regs_q[g*REG_WIDTH +: REG_WIDTH] = r[g];
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl: random and directed commands checked against a behavioural register/memory model.
module tb_reg_access_ctrl;
    localparam int NR = 4, RW = 40, MD = 256, AW = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reg_access_ctrl_if bus();
    logic [NR*RW-1:0] regs_q;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;
`ifdef RAC_HW_UPDATE_EN
    logic [NR-1:0]    hw_we;
    logic [NR*RW-1:0] hw_wdata;
`endif

    reg_access_ctrl #(.NUM_REGS(NR), .REG_WIDTH(RW), .MEM_DEPTH(MD)) dut (
        .clock(clock), .reset(reset), .bus(bus), .regs_q(regs_q),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef RAC_HW_UPDATE_EN
        , .hw_we(hw_we), .hw_wdata(hw_wdata)
`endif
    );

    logic [31:0] ram [MD] = '{default: 32'd0};
    always @(posedge clock)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    int en_cnt = 0, we_cnt = 0;
    always @(negedge clock) begin
        if (mem_en) en_cnt++;
        if (mem_en && mem_we) we_cnt++;
    end

    logic [63:0] m_regs [NR];
    logic [31:0] m_mem  [MD];
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) check("regs_q", 64'(regs_q[i*RW +: RW]), m_regs[i]);
    endtask

    task automatic do_cmd(input int op, input int id, input int msk, input logic [31:0] din, input int hold);
        logic [31:0] exp_out, held;
        logic        exp_err;
        int          exp_lat, lat, e0, w0;
        exp_err = op > 4 || ((op == 1 || op == 2) && (id >= NR || msk >= 2)) || ((op == 3 || op == 4) && id >= MD);
        exp_lat = (exp_err || op < 3) ? 1 : (op == 3 ? 2 : 3);
        if (exp_err) exp_out = 32'hBADC0DE0;
        else if (op == 0) exp_out = 32'hDEADBEEF;
        else if (op == 1) begin
            exp_out = din;
            m_regs[id][msk*32 +: 32] = din;
            m_regs[id] = m_regs[id] & ((64'd1 << RW) - 64'd1);
        end
        else if (op == 2) exp_out = m_regs[id][msk*32 +: 32];
        else if (op == 3) begin
            exp_out = din;
            m_mem[id] = din;
        end
        else exp_out = m_mem[id];
        @(negedge clock);
        for (int k = 0; k < 20 && !bus.cmd_ready; k++) @(negedge clock);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_id     = id;
        bus.cmd_mask   = msk;
        bus.cmd_in     = din;
        e0 = en_cnt;
        w0 = we_cnt;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_out", bus.rsp_out, exp_out);
        check("rsp_err", bus.rsp_err, exp_err);
        check("cmd_ready_busy", bus.cmd_ready, 0);
        check("mem_en_cycles", en_cnt - e0, (!exp_err && op >= 3) ? 1 : 0);
        check("mem_we_cycles", we_cnt - w0, (!exp_err && op == 3) ? 1 : 0);
        if (!exp_err && op >= 3) check("mem_addr", mem_addr, AW'(id));
        if (!exp_err && op == 3) check("mem_wdata", mem_wdata, din);
        check_regs();
        held = bus.rsp_out;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_out", bus.rsp_out, held);
            check("hold_no_accept", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clock);
        check("rsp_drop", bus.rsp_valid, 0);
        check("ready_after", bus.cmd_ready, 1);
    endtask

    initial begin
        int op, id, msk;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_opcode = 0; bus.cmd_id = 0; bus.cmd_mask = 0; bus.cmd_in = 0;
`ifdef RAC_HW_UPDATE_EN
        hw_we = '0; hw_wdata = '0;
`endif
        for (int i = 0; i < NR; i++) m_regs[i] = 64'd0;
        for (int i = 0; i < MD; i++) m_mem[i] = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_out", bus.rsp_out, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check_regs();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", bus.cmd_ready, 1);

        do_cmd(0, 0, 0, 32'h0, 0);
        do_cmd(1, 2, 1, 32'hFFFFFFFF, 0);
        do_cmd(2, 2, 1, 32'h0, 0);
        do_cmd(2, 2, 0, 32'h0, 0);
        do_cmd(1, NR, 0, 32'hA5A5A5A5, 0);
        do_cmd(7, 0, 0, 32'h0, 0);
        do_cmd(1, 0, 2, 32'h1, 0);
        do_cmd(3, 5, 0, 32'h12345678, 0);
        do_cmd(4, 5, 0, 32'h0, 0);
        do_cmd(3, MD, 0, 32'h55, 0);
        do_cmd(0, 0, 0, 32'h0, 10);

        // Reset lands while a memory read is in flight.
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 4; bus.cmd_id = 5; bus.cmd_mask = 0;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 64'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("abort_rsp_valid", bus.rsp_valid, 0);
            check("abort_mem_en", mem_en, 0);
        end
        check("abort_ready", bus.cmd_ready, 1);
        check_regs();

`ifdef RAC_HW_UPDATE_EN
        @(negedge clock);
        hw_we = 4'b0010;
        hw_wdata = '0;
        hw_wdata[RW +: RW] = 40'hAB_CDEF_0123;
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 1; bus.cmd_id = 1; bus.cmd_mask = 0; bus.cmd_in = 32'h11223344;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        hw_we = '0;
        m_regs[1] = 64'hAB_1122_3344;
        @(negedge clock);
        check("hw_rsp_out", bus.rsp_out, 32'h11223344);
        check_regs();
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
`endif

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 5);
            if (op == 5) op = 4 + $urandom_range(1, 12);
            msk = $urandom_range(0, 2);
            id = (op == 3 || op == 4) ? $urandom_range(0, 9) : $urandom_range(0, NR);
            if ((op == 3 || op == 4) && id == 9) id = MD;
            do_cmd(op, id, msk, $urandom, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
